// File: rtl/jt12_pkg.sv
// jt12_pkg: shared register numbers, channel-3 mode codes and CSM sequencer states
package jt12_pkg;

    localparam logic [7:0] REG_TA_HI = 8'h24;
    localparam logic [7:0] REG_TA_LO = 8'h25;
    localparam logic [7:0] REG_TB    = 8'h26;
    localparam logic [7:0] REG_MODE  = 8'h27;

    localparam logic [1:0] CH3_NORMAL  = 2'b00;
    localparam logic [1:0] CH3_SPECIAL = 2'b01;
    localparam logic [1:0] CH3_CSM     = 2'b10;

    typedef enum logic {
        CSM_IDLE  = 1'b0,
        CSM_KEYON = 1'b1
    } csm_state_t;

endpackage

// File: rtl/jt12_timer_ctrl_if.sv
// jt12_timer_ctrl_if: CPU-side register bus (strobe, A0, data, status readback)
interface jt12_timer_ctrl_if;
    logic       write;
    logic       addr;
    logic [7:0] din;
    logic [7:0] status;

    modport master (output write, addr, din, input status);
    modport slave  (input write, addr, din, output status);
endinterface

// File: rtl/jt12_csm_seq.sv
// jt12_csm_seq: two-state CSM key-on sequencer driven by Timer A overflow
module jt12_csm_seq
    import jt12_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       zero,
    input  logic       load_A,
    input  logic       overflow_A,
    input  logic [1:0] ch3_mode,
    output logic       csm_keyon
);

    csm_state_t state;
    logic csm_on, sample, ovf;

    assign csm_on = ch3_mode == CH3_CSM;
    assign sample = clk_en && zero;
    assign ovf    = csm_on && sample && load_A && overflow_A;

    // key-on spans one sample period; a repeated overflow keeps it held, leaving CSM drops it at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CSM_IDLE;
            csm_keyon <= 1'b0;
        end else begin
            case (state)
                CSM_IDLE:
                    if (ovf) begin
                        state     <= CSM_KEYON;
                        csm_keyon <= 1'b1;
                    end
                CSM_KEYON:
                    if (!csm_on || (sample && !ovf)) begin
                        state     <= CSM_IDLE;
                        csm_keyon <= 1'b0;
                    end
            endcase
        end
    end

endmodule

// File: rtl/jt12_timer_ctrl.sv
// jt12_timer_ctrl: timer register decode, write-busy counter and CSM key-on control
module jt12_timer_ctrl
    import jt12_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              zero,
    input  logic              flag_A,
    input  logic              flag_B,
    input  logic              overflow_A,
    jt12_timer_ctrl_if.slave  bus,
    output logic [9:0]        value_A,
    output logic [7:0]        value_B,
    output logic              load_A,
    output logic              load_B,
    output logic              clr_flag_A,
    output logic              clr_flag_B,
    output logic              enable_irq_A,
    output logic              enable_irq_B,
    output logic [1:0]        ch3_mode,
    output logic              csm_keyon,
    output logic              busy
);

    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);

    logic [7:0]    reg_sel;
    logic [BW-1:0] busy_cnt;
    logic          addr_wr, data_wr;

    assign addr_wr = bus.write && !bus.addr;
    assign data_wr = bus.write && bus.addr;

    // register-number latch and data-phase decode; clear strobes last one clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_sel      <= 8'h00;
            value_A      <= '0;
            value_B      <= '0;
            ch3_mode     <= CH3_NORMAL;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
        end else begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (addr_wr) reg_sel <= bus.din;
            if (data_wr) begin
                case (reg_sel)
                    REG_TA_HI: value_A[9:2] <= bus.din;
                    REG_TA_LO: value_A[1:0] <= bus.din[1:0];
                    REG_TB:    value_B      <= bus.din;
                    REG_MODE: begin
                        ch3_mode     <= bus.din[7:6];
                        clr_flag_B   <= bus.din[5];
                        clr_flag_A   <= bus.din[4];
                        enable_irq_B <= bus.din[3];
                        enable_irq_A <= bus.din[2];
                        load_B       <= bus.din[1];
                        load_A       <= bus.din[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // busy countdown: any data write reloads (taking priority), clk_en counts down to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= '0;
        else if (data_wr) busy_cnt <= BUSY_LOAD;
        else if (clk_en && busy_cnt != '0) busy_cnt <= busy_cnt - BW'(1);
    end

    assign busy       = busy_cnt != '0;
    assign bus.status = {busy, 5'b0, flag_B, flag_A};

    jt12_csm_seq u_csm (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .zero       (zero),
        .load_A     (load_A),
        .overflow_A (overflow_A),
        .ch3_mode   (ch3_mode),
        .csm_keyon  (csm_keyon)
    );

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// tb_jt12_timer_ctrl: directed checks of register decode, busy timing and CSM key-on
module tb_jt12_timer_ctrl;

    logic       clk = 1'b0, rst = 1'b1;
    logic       clk_en = 1'b0, zero = 1'b0, flag_A = 1'b0, flag_B = 1'b0, overflow_A = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_flag_A, clr_flag_B, enable_irq_A, enable_irq_B;
    logic [1:0] ch3_mode;
    logic       csm_keyon, busy;
    int         n_cmp = 0, n_bad = 0;

    jt12_timer_ctrl_if bus ();

    jt12_timer_ctrl #(.BUSY_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero),
        .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
        .bus(bus),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .ch3_mode(ch3_mode), .csm_keyon(csm_keyon), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d, input logic en);
        bus.write = 1'b1;
        bus.addr  = 1'b0;
        bus.din   = a;
        tick();
        bus.addr  = 1'b1;
        bus.din   = d;
        clk_en    = en;
        tick();
        bus.write = 1'b0;
        clk_en    = 1'b0;
    endtask

    task automatic pulse_en();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        tick();
    endtask

    task automatic zero_cycle(input logic ovf);
        clk_en     = 1'b1;
        zero       = 1'b1;
        overflow_A = ovf;
        tick();
        clk_en     = 1'b0;
        zero       = 1'b0;
        overflow_A = 1'b0;
    endtask

    task automatic test_reset();
        bus.write = 1'b0;
        bus.addr  = 1'b0;
        bus.din   = 8'h00;
        tick();
        tick();
        n_cmp++;
        if ({value_A, value_B, ch3_mode} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_values got A=%h B=%h mode=%b want 0", value_A, value_B, ch3_mode);
        end
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, csm_keyon, busy} !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, csm_keyon, busy});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.status !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_status got %h want 00", bus.status);
        end
    endtask

    task automatic test_values();
        write_reg(8'h24, 8'hFF, 1'b0);
        n_cmp++;
        if (value_A !== 10'h3FC) begin
            n_bad++;
            $display("FAIL ta_hi got %h want 3fc", value_A);
        end
        write_reg(8'h25, 8'h03, 1'b0);
        n_cmp++;
        if (value_A !== 10'h3FF) begin
            n_bad++;
            $display("FAIL ta_lo got %h want 3ff", value_A);
        end
        write_reg(8'h26, 8'hC8, 1'b0);
        n_cmp++;
        if (value_B !== 8'hC8) begin
            n_bad++;
            $display("FAIL tb got %h want c8", value_B);
        end
        write_reg(8'h28, 8'h55, 1'b0);
        n_cmp++;
        if ({value_A, value_B, busy} !== {10'h3FF, 8'hC8, 1'b1}) begin
            n_bad++;
            $display("FAIL other_reg got A=%h B=%h busy=%b want 3ff c8 1", value_A, value_B, busy);
        end
    endtask

    task automatic test_mode();
        write_reg(8'h27, 8'h3F, 1'b0);
        n_cmp++;
        if ({ch3_mode, load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B} !== 8'b00_111111) begin
            n_bad++;
            $display("FAIL mode_3f got %b want 00111111",
                     {ch3_mode, load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B});
        end
        tick();
        n_cmp++;
        if ({load_A, load_B, clr_flag_A, clr_flag_B} !== 4'b1100) begin
            n_bad++;
            $display("FAIL clr_width got %b want 1100", {load_A, load_B, clr_flag_A, clr_flag_B});
        end
        write_reg(8'h27, 8'h10, 1'b0);
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, clr_flag_A, clr_flag_B} !== 5'b00010) begin
            n_bad++;
            $display("FAIL clr_a_only got %b want 00010", {load_A, load_B, enable_irq_A, clr_flag_A, clr_flag_B});
        end
        write_reg(8'h27, 8'h0F, 1'b0);
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B} !== 6'b111100) begin
            n_bad++;
            $display("FAIL mode_0f got %b want 111100",
                     {load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B});
        end
    endtask

    task automatic test_busy();
        int cnt;
        for (int i = 0; i < 100 && busy; i++) pulse_en();
        flag_A = 1'b1;
        write_reg(8'h26, 8'hC8, 1'b0);
        n_cmp++;
        if (bus.status !== 8'h81) begin
            n_bad++;
            $display("FAIL status_busy got %h want 81", bus.status);
        end
        cnt = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            pulse_en();
            cnt++;
            n_cmp++;
            if (bus.status[7] !== busy || bus.status[6:0] !== 7'h01) begin
                n_bad++;
                $display("FAIL status_track got %h busy=%b", bus.status, busy);
            end
        end
        n_cmp++;
        if (cnt !== 32) begin
            n_bad++;
            $display("FAIL busy_len got %0d want 32", cnt);
        end
        flag_A = 1'b0;
        flag_B = 1'b1;
        write_reg(8'h26, 8'hC8, 1'b0);
        for (int i = 0; i < 19; i++) pulse_en();
        write_reg(8'h26, 8'hC8, 1'b1);
        tick();
        cnt = 20;
        for (int i = 0; i < 100 && busy; i++) begin
            pulse_en();
            cnt++;
        end
        n_cmp++;
        if (cnt !== 52) begin
            n_bad++;
            $display("FAIL busy_ext got %0d want 52", cnt);
        end
        n_cmp++;
        if (bus.status !== 8'h02) begin
            n_bad++;
            $display("FAIL status_idle got %h want 02", bus.status);
        end
        flag_B = 1'b0;
    endtask

    task automatic test_csm();
        write_reg(8'h27, 8'h81, 1'b0);
        n_cmp++;
        if (ch3_mode !== 2'b10 || load_A !== 1'b1) begin
            n_bad++;
            $display("FAIL csm_mode got mode=%b load_A=%b want 10 1", ch3_mode, load_A);
        end
        zero_cycle(1'b1);
        n_cmp++;
        if (csm_keyon !== 1'b1) begin
            n_bad++;
            $display("FAIL csm_on got %b want 1", csm_keyon);
        end
        tick();
        tick();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        tick();
        n_cmp++;
        if (csm_keyon !== 1'b1) begin
            n_bad++;
            $display("FAIL csm_hold got %b want 1", csm_keyon);
        end
        zero_cycle(1'b0);
        n_cmp++;
        if (csm_keyon !== 1'b0) begin
            n_bad++;
            $display("FAIL csm_off got %b want 0", csm_keyon);
        end
        write_reg(8'h27, 8'h01, 1'b0);
        zero_cycle(1'b1);
        tick();
        n_cmp++;
        if (csm_keyon !== 1'b0) begin
            n_bad++;
            $display("FAIL csm_normal got %b want 0", csm_keyon);
        end
        write_reg(8'h27, 8'h80, 1'b0);
        zero_cycle(1'b1);
        tick();
        n_cmp++;
        if (csm_keyon !== 1'b0) begin
            n_bad++;
            $display("FAIL csm_noload got %b want 0", csm_keyon);
        end
    endtask

    task automatic test_back_to_back();
        write_reg(8'h27, 8'h81, 1'b0);
        zero_cycle(1'b1);
        tick();
        zero_cycle(1'b1);
        n_cmp++;
        if (csm_keyon !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second got %b want 1", csm_keyon);
        end
        tick();
        n_cmp++;
        if (csm_keyon !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_held got %b want 1", csm_keyon);
        end
        write_reg(8'h27, 8'h01, 1'b0);
        tick();
        n_cmp++;
        if (csm_keyon !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_modeoff got %b want 0", csm_keyon);
        end
    endtask

    task automatic test_async_reset();
        write_reg(8'h27, 8'h8F, 1'b0);
        zero_cycle(1'b1);
        write_reg(8'h26, 8'h11, 1'b0);
        n_cmp++;
        if ({csm_keyon, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL pre_rst got %b want 11", {csm_keyon, busy});
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({value_A, value_B, ch3_mode} !== 20'h0 || bus.status !== 8'h00) begin
            n_bad++;
            $display("FAIL async_vals got A=%h B=%h mode=%b st=%h want 0", value_A, value_B, ch3_mode, bus.status);
        end
        n_cmp++;
        if ({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, csm_keyon, busy} !== 8'h0) begin
            n_bad++;
            $display("FAIL async_ctrl got %b want 00000000",
                     {load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, csm_keyon, busy});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_values();
        test_mode();
        test_busy();
        test_csm();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jt12_timer_ctrl.md
# jt12_timer_ctrl

Register-side controller for the YM2612 timer pair: decodes CPU address/data writes to registers 0x24–0x27, holds the Timer A/B reload values and mode bits, and generates the load, flag-clear and IRQ-enable controls for `jt12_timers`. It also sequences CSM (composite sine mode) key-on pulses for channel 3 from Timer A overflow, and produces the status byte with the write-busy flag. It sits between the CPU bus interface and `jt12_timers`.

## Interface
- `BUSY_CYCLES`, 32, number of `clk_en` cycles the busy flag stays high after a data write.
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-high reset.
- `clk_en` in 1 — chip clock enable, same enable as the timers.
- `zero` in 1 — slot-sequencer zero marker; one `clk_en` per sample period.
- `write` in 1 — one-`clk` CPU write strobe.
- `addr` in 1 — A0: 0 = register-number phase, 1 = data phase.
- `din` in 8 — CPU data.
- `flag_A`, `flag_B` in 1 each — timer flags from `jt12_timers`.
- `overflow_A` in 1 — Timer A combinational overflow.
- `value_A` out 10, `value_B` out 8 — reload values.
- `load_A`, `load_B` out 1 — timer run enables (level).
- `clr_flag_A`, `clr_flag_B` out 1 — one-`clk` flag-clear pulses.
- `enable_irq_A`, `enable_irq_B` out 1 — IRQ masks.
- `ch3_mode` out 2 — 00 normal, 01 special, 10 CSM, 11 special.
- `csm_keyon` out 1 — key-on request for all four channel-3 operators.
- `busy` out 1 — write-busy flag.
- `status` out 8 — {busy, 5'b0, flag_B, flag_A}.

## Operation
- Address phase (`write` && !`addr`): latch `din` into `reg_sel`; `reg_sel` resets to 0x00.
- Data phase (`write` && `addr`): the selected register is written. Other register numbers are ignored by this block but still restart busy.
  - 0x24 → `value_A[9:2]`.
  - 0x25 → `value_A[1:0]` ← `din[1:0]`.
  - 0x26 → `value_B`.
  - 0x27 → `ch3_mode` ← `din[7:6]`; `enable_irq_B` ← `din[3]`; `enable_irq_A` ← `din[2]`; `load_B` ← `din[1]`; `load_A` ← `din[0]`. If `din[5]`, pulse `clr_flag_B`; if `din[4]`, pulse `clr_flag_A`. The clear bits are not stored.
- Value writes never disturb a running counter; the timer picks them up on its next load edge or overflow.
- Busy:
  - Any data-phase write loads the busy counter with `BUSY_CYCLES`; `busy` = counter != 0.
  - The counter decrements on `clk_en` and saturates at 0.
  - Writes while busy are still accepted and restart the count.
- CSM state machine, states IDLE and KEYON:
  - IDLE→KEYON when `ch3_mode`==10 && `clk_en` && `zero` && `load_A` && `overflow_A`.
  - KEYON→IDLE on the next `clk_en`&&`zero`, unless the overflow condition is true again in that same cycle; then it stays in KEYON.
  - KEYON→IDLE immediately (next `clk`) if `ch3_mode` != 10.
  - `csm_keyon` = (state == KEYON).

## Timing
- All outputs are registered and update on the `clk` edge after the qualifying strobe (one-cycle latency).
- Values on reset:
  - `value_A`, `value_B`, `ch3_mode` = 0.
  - `load_*`, `enable_irq_*`, `clr_flag_*` = 0.
  - `csm_keyon` = 0; CSM state = IDLE.
  - Busy counter = 0 (`busy` = 0).
- `clr_flag_*` is exactly one `clk` wide, regardless of `clk_en`.
- `csm_keyon` stays high for exactly one sample period (one `zero` interval) per overflow.
- Simultaneous address and data strobes cannot occur (single `addr` bit).
- A data write and a busy decrement in the same `clk`: the reload wins.
- Reset mid-KEYON drops `csm_keyon` asynchronously.
- Width rules:
  - The busy counter is $clog2(`BUSY_CYCLES`+1) bits wide.
  - Counter arithmetic is unsigned.
  - `status` bits [6:2] are always 0.

## Structure
- Shared package `jt12_pkg`:
  - Register-number constants: `REG_TA_HI`=8'h24, `REG_TA_LO`=8'h25, `REG_TB`=8'h26, `REG_MODE`=8'h27.
  - `ch3_mode` codes: `CH3_NORMAL`, `CH3_SPECIAL`, `CH3_CSM`.
- One sub-module, `jt12_csm_seq`: the two-state CSM key-on sequencer. Inputs: `ch3_mode`, `overflow_A`, `load_A`, `zero`, `clk_en`. Output: `csm_keyon`.
- Register decode and the busy counter stay in the top level.

## Test plan
- Write 0x24←0xFF, 0x25←0x03, 0x26←0xC8 → `value_A`=0x3FF and `value_B`=0xC8, each one `clk` after its data strobe.
- Write 0x27←0x3F → `load_A`/`load_B`/`enable_irq_*` = 1, `clr_flag_A` and `clr_flag_B` each high for one `clk`, and neither clear bit is retained.
- Data write → `busy` high for exactly 32 `clk_en` pulses; a second write at pulse 20 extends it to 52 total; `status[7]` tracks `busy`.
- 0x27←0x81 with `value_A`=0x3FF, drive `overflow_A` on a `zero` cycle → `csm_keyon` high for exactly one `zero` interval. Repeat with 0x27←0x01 → `csm_keyon` stays 0.
- Overflow on two consecutive `zero` cycles → `csm_keyon` held continuously. Writing 0x27←0x01 mid-KEYON → drops next `clk`.
- Assert `rst` mid-KEYON with `busy`=1 → all outputs return to their reset values asynchronously.
